// File: rtl/matrix_seq_pkg.sv
// Shared types and RAM-select encodings for the matrix multiply sequencer.
package matrix_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_X    = 3'd1,
        LOAD_Y    = 3'd2,
        START     = 3'd3,
        WAIT_RUN  = 3'd4,
        WAIT_DONE = 3'd5,
        READ_ADDR = 3'd6,
        READ_CAP  = 3'd7
    } seq_state_t;

    localparam logic [1:0] SEL_X    = 2'b00;
    localparam logic [1:0] SEL_Y    = 2'b01;
    localparam logic [1:0] SEL_Z    = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

endpackage

// File: rtl/matrix_multiply_sequencer.sv
// Streams X/Y operands into the multiplier RAMs, kicks off the multiply, and
// streams the Z result back out over a valid/ready interface.
module matrix_multiply_sequencer
    import matrix_seq_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int X_ROWS        = 5,
    parameter int Y_COLS        = 5,
    parameter int X_COLS_Y_ROWS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  done,
    output logic                  start,
    input  logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wen,
    output logic [1:0]            ram_sel,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam logic [ADDR_WIDTH-1:0] X_LAST  = ADDR_WIDTH'(X_ROWS * X_COLS_Y_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] Y_LAST  = ADDR_WIDTH'(X_COLS_Y_ROWS * Y_COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] Z_LAST  = ADDR_WIDTH'(X_ROWS * Y_COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    seq_state_t            state_r, state_s;
    logic [ADDR_WIDTH-1:0] cnt_r, cnt_s;
    logic [DATA_WIDTH-1:0] m_data_r;
    logic                  m_valid_r;
    logic                  m_last_r;
    logic                  done_r;

    // State and word-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state, counter update and per-state control decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        s_ready = 1'b0;
        start   = 1'b0;
        ram_sel = SEL_NONE;
        case (state_r)
            IDLE: begin
                if (go) begin
                    state_s = LOAD_X;
                    cnt_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD_X: begin
                s_ready = 1'b1;
                ram_sel = SEL_X;
                if (s_valid && (cnt_r == X_LAST)) begin
                    cnt_s   = '0;
                    state_s = LOAD_Y;
                end else if (s_valid) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            LOAD_Y: begin
                s_ready = 1'b1;
                ram_sel = SEL_Y;
                if (s_valid && (cnt_r == Y_LAST)) begin
                    cnt_s   = '0;
                    state_s = START;
                end else if (s_valid) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            START: begin
                start   = 1'b1;
                state_s = WAIT_RUN;
            end
            WAIT_RUN: begin
                if (busy) begin
                    state_s = WAIT_DONE;
                end else begin
                    state_s = WAIT_RUN;
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    state_s = READ_ADDR;
                    cnt_s   = '0;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            READ_ADDR: begin
                ram_sel = SEL_Z;
                state_s = READ_CAP;
            end
            READ_CAP: begin
                ram_sel = SEL_Z;
                // Leave only once the captured word has been accepted downstream.
                if (m_valid_r && m_ready && m_last_r) begin
                    cnt_s   = '0;
                    state_s = IDLE;
                end else if (m_valid_r && m_ready) begin
                    cnt_s   = cnt_r + CNT_ONE;
                    state_s = READ_ADDR;
                end else begin
                    state_s = READ_CAP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Result capture, hold-under-backpressure and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_r  <= '0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state_r == READ_CAP) begin
                // First READ_CAP cycle sees the synchronous RAM read data.
                if (!m_valid_r) begin
                    m_data_r  <= ram_data_out;
                    m_valid_r <= 1'b1;
                    m_last_r  <= (cnt_r == Z_LAST);
                end else if (m_ready) begin
                    m_valid_r <= 1'b0;
                    m_last_r  <= 1'b0;
                    done_r    <= m_last_r;
                end
            end
        end
    end

    assign ram_addr    = cnt_r;
    assign ram_wen     = s_valid & s_ready;
    assign ram_data_in = s_data;
    assign m_data      = m_data_r;
    assign m_valid     = m_valid_r;
    assign m_last      = m_last_r;
    assign done        = done_r;

endmodule

// File: doc/matrix_multiply_sequencer.md
# matrix_multiply_sequencer

Sequencer placed directly in front of `matrix_multiply_top`. It streams X and Y operand words from a valid/ready source into the X and Y RAMs through the top's RAM port, then pulses `start` and waits for the multiply to complete. It then reads every Z word back and presents it on a valid/ready output stream. The result is a matrix multiply behind two streams, with no host-side RAM addressing.

## Interface
- `ADDR_WIDTH`, 32: width of `ram_addr`; must cover `max(X_ROWS*X_COLS_Y_ROWS, X_COLS_Y_ROWS*Y_COLS, X_ROWS*Y_COLS)`.
- `DATA_WIDTH`, 32: operand/result word width.
- `X_ROWS`, 5: rows of X and Z.
- `Y_COLS`, 5: columns of Y and Z.
- `X_COLS_Y_ROWS`, 5: shared inner dimension.
- Clocking: one clock; reset is asynchronous and active-high (`clk`, `rst`).
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: asynchronous active-high reset.
- `go` in 1: one-cycle request to run a job; honoured only in IDLE.
- `s_valid` in 1: input operand word valid.
- `s_ready` out 1: sequencer accepts an operand word.
- `s_data` in DATA_WIDTH: operand word; all X words first, then all Y words, row-major.
- `m_valid` out 1: result word valid.
- `m_ready` in 1: downstream accepts a result word.
- `m_data` out DATA_WIDTH: Z word, row-major.
- `m_last` out 1: marks the final Z word (Z address `X_ROWS*Y_COLS-1`).
- `done` out 1: one-cycle pulse after the last Z handshake.
- `start` out 1: to multiplier top; one-cycle pulse.
- `busy` in 1: from multiplier top.
- `ram_addr` out ADDR_WIDTH: RAM port address.
- `ram_wen` out 1: RAM port write enable.
- `ram_sel` out 2: 00 = X, 01 = Y, 10 = Z, 11 = none.
- `ram_data_in` out DATA_WIDTH: write data (equals `s_data`).
- `ram_data_out` in DATA_WIDTH: read data. It is valid one cycle after `ram_addr`/`ram_sel` are presented (synchronous RAM read).

## Operation
States and transitions:
- **IDLE**: `go` moves to LOAD_X with the counter cleared.
- **LOAD_X**: `s_ready`=1, `ram_sel`=00, `ram_addr`=counter. `ram_wen = s_valid & s_ready` (combinational). The counter increments on each handshake. The handshake at count `X_ROWS*X_COLS_Y_ROWS-1` clears the counter and moves to LOAD_Y.
- **LOAD_Y**: same behaviour with `ram_sel`=01 and terminal count `X_COLS_Y_ROWS*Y_COLS-1`. Moves to START.
- **START**: `start`=1 for exactly this cycle, `s_ready`=0, `ram_sel`=11. Moves to WAIT_RUN.
- **WAIT_RUN**: wait for `busy`=1, then move to WAIT_DONE.
- **WAIT_DONE**: wait for `busy`=0, then move to READ_ADDR with the counter cleared.
- **READ_ADDR**: `ram_sel`=10, `ram_addr`=counter. Next state READ_CAP.
- **READ_CAP**: `ram_sel`/`ram_addr` held. `ram_data_out` is registered into `m_data`, and `m_valid`=1 from the following cycle until the handshake. `m_last` is set when counter = `X_ROWS*Y_COLS-1`.
  - On a handshake that is not last: counter increments, go to READ_ADDR.
  - On the last handshake: `done` pulses, go to IDLE.

Rules and boundary conditions:
- `ram_wen` is 0 in every state except LOAD_X and LOAD_Y. The sequencer never writes Z.
- `ram_sel` is 11 in IDLE, START, WAIT_RUN and WAIT_DONE.
- `go` outside IDLE is ignored; no queuing.
- `s_valid` gaps stall loading indefinitely with no timeout.
- `m_ready` low holds `m_data` and `m_last` stable; `m_valid` never drops before the handshake.
- Counters are ADDR_WIDTH wide and compare against the terminal count only; no wrap occurs within a job.
- `rst` at any time returns to IDLE and abandons the job. Partially written RAM contents are not cleared.

## Timing
- Reset values: `s_ready`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `done`=0, `start`=0, `ram_wen`=0, `ram_addr`=0, `ram_sel`=11.
- `go` sampled at edge N puts the block in LOAD_X, with `s_ready`=1 during cycle N+1.
- Each operand handshake costs 1 cycle; the write occurs on the same edge as the handshake.
- `start` is high exactly 1 cycle, in the cycle after the last Y handshake.
- Result throughput is one word per 3 cycles when `m_ready`=1 (READ_ADDR, capture, valid).
- Latency from `busy` falling to the first `m_valid` is 3 cycles.
- `done` is high in the cycle after the last `m_valid & m_ready`.

## Structure
- Package `matrix_seq_pkg` holds:
  - the state enum (IDLE, LOAD_X, LOAD_Y, START, WAIT_RUN, WAIT_DONE, READ_ADDR, READ_CAP);
  - `ram_sel` constants (`SEL_X`, `SEL_Y`, `SEL_Z`, `SEL_NONE`).
- Single module; no sub-module is warranted.
- Terminal counts are localparams derived from the module parameters.

## Test plan
- **Reset values:** assert `rst` mid-cycle with no clock edge -> all outputs at reset values immediately; `ram_sel`=11.
- **Identity job (5x5):** X = identity, Y = 1..25, full-rate streams -> 25 `ram_wen` pulses to X then to Y, one `start` pulse, `m_data` = 1..25 in order, `m_last` on 25, `done` one cycle later.
- **Backpressure:** random `s_valid` gaps and `m_ready` toggling on the identity job -> same 25 results; `m_data` stable while `m_valid & ~m_ready`.
- **Non-square (X_ROWS=2, X_COLS_Y_ROWS=3, Y_COLS=4):** X = 1..6, Y = all 1 -> 6 X writes, 12 Y writes, 8 results `{6,6,6,6,15,15,15,15}`.
- **Ignored go:** `go` pulsed during LOAD_Y and WAIT_DONE -> no state change, exactly one job executes.
- **Reset mid-operation:** `rst` during LOAD_Y after 7 words -> IDLE, `s_ready`=0. A following `go` restarts at X address 0.
